// File: rtl/snes_pkg.sv
// Shared constants and FSM encoding for the SNES pad reader.
package snes_pkg;

   localparam int NUM_BTNS   = 12;
   localparam int NUM_PULSES = 16;

   localparam int BTN_B      = 0;
   localparam int BTN_Y      = 1;
   localparam int BTN_SELECT = 2;
   localparam int BTN_START  = 3;
   localparam int BTN_UP     = 4;
   localparam int BTN_DOWN   = 5;
   localparam int BTN_LEFT   = 6;
   localparam int BTN_RIGHT  = 7;
   localparam int BTN_A      = 8;
   localparam int BTN_X      = 9;
   localparam int BTN_L      = 10;
   localparam int BTN_R      = 11;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LATCH   = 3'd1,
      ST_GAP     = 3'd2,
      ST_CLK_LO  = 3'd3,
      ST_CLK_HI  = 3'd4,
      ST_PUBLISH = 3'd5
   } snes_state_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; resets to 1 (line released).
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic stage1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stage1 <= 1'b1;
         q      <= 1'b1;
      end else begin
         stage1 <= d;
         q      <= stage1;
      end
   end

endmodule

// File: rtl/snes_pad_reader.sv
// Periodically scans a SNES serial gamepad and publishes a registered pressed-button vector.
module snes_pad_reader
   import snes_pkg::*;
#(
   parameter int CLK_DIV  = 150,
   parameter int POLL_DIV = 416667
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                pad_data,
   output logic                pad_latch,
   output logic                pad_clk,
   output logic [NUM_BTNS-1:0] buttons,
   output logic                buttons_valid,
   output logic                pad_present
);

   localparam int CNT_W_RAW = $clog2(max_int(POLL_DIV, 2 * CLK_DIV));
   localparam int CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;

   localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'(POLL_DIV - 1);
   localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(2 * CLK_DIV - 1);
   localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(CLK_DIV - 1);
   localparam logic [4:0]       LAST_PULSE = 5'(NUM_PULSES);

   snes_state_t           state, state_nxt;
   logic [CNT_W-1:0]      cnt, cnt_nxt;
   logic [4:0]            pulse, pulse_nxt;
   logic [NUM_PULSES-1:0] raw, raw_nxt;
   logic                  data_sync;
   logic                  present;

   sync_2ff u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (pad_data),
      .q     (data_sync)
   );

   // The pad reports four trailing ones after the twelve buttons; a floating-low line never does.
   assign present = &raw[NUM_PULSES-1:NUM_BTNS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         cnt   <= '0;
         pulse <= '0;
         raw   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         pulse <= pulse_nxt;
         raw   <= raw_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt + 1'b1;
      pulse_nxt = pulse;
      raw_nxt   = raw;
      unique case (state)
         ST_IDLE: begin
            if (cnt == IDLE_LAST) begin
               state_nxt = ST_LATCH;
               cnt_nxt   = '0;
            end
         end
         ST_LATCH: begin
            if (cnt == LATCH_LAST) begin
               state_nxt = ST_GAP;
               cnt_nxt   = '0;
            end
         end
         ST_GAP: begin
            if (cnt == HALF_LAST) begin
               raw_nxt[0] = data_sync;
               pulse_nxt  = 5'd1;
               state_nxt  = ST_CLK_LO;
               cnt_nxt    = '0;
            end
         end
         ST_CLK_LO: begin
            if (cnt == HALF_LAST) begin
               state_nxt = ST_CLK_HI;
               cnt_nxt   = '0;
            end
         end
         ST_CLK_HI: begin
            if (cnt == HALF_LAST) begin
               cnt_nxt = '0;
               // The sixteenth pulse only returns the pad to idle; its sample carries nothing.
               if (pulse == LAST_PULSE) begin
                  pulse_nxt = '0;
                  state_nxt = ST_PUBLISH;
               end else begin
                  raw_nxt[pulse[3:0]] = data_sync;
                  pulse_nxt = pulse + 5'd1;
                  state_nxt = ST_CLK_LO;
               end
            end
         end
         ST_PUBLISH: begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
         end
         default: begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Pad-facing strobes are registered from the next state so they line up with the state itself.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pad_latch     <= 1'b0;
         pad_clk       <= 1'b1;
         buttons       <= '0;
         buttons_valid <= 1'b0;
         pad_present   <= 1'b0;
      end else begin
         pad_latch     <= (state_nxt == ST_LATCH);
         pad_clk       <= (state_nxt != ST_CLK_LO);
         buttons_valid <= (state == ST_PUBLISH);
         if (state == ST_PUBLISH) begin
            pad_present <= present;
            buttons     <= present ? ~raw[NUM_BTNS-1:0] : '0;
         end
      end
   end

endmodule
